// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity checker.
//   state_t    : FSM state encoding (IDLE/DATA/PAR)
//   par_mode_t : parity sense; PAR_MODE fixes the checker to even parity
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  typedef enum logic {
    PAR_MODE_EVEN = 1'b0,
    PAR_MODE_ODD  = 1'b1
  } par_mode_t;

  localparam par_mode_t PAR_MODE = PAR_MODE_EVEN;

endpackage

// File: rtl/serial_parity_checker_if.sv
// Handshake/result bundle for serial_parity_checker.
//   start, bit_in, bit_valid : stimulus into the checker (master drives)
//   busy, done, data_out, par_err : frame status and result (slave drives)
//   err_cnt : saturating failed-frame count, only when ERR_CNT_EN is defined
// Optional feature macro: ERR_CNT_EN
interface serial_parity_checker_if #(
  parameter int DATA_BITS = 8
`ifdef ERR_CNT_EN
  , parameter int CNT_W = 8
`endif
);
  logic                 start;
  logic                 bit_in;
  logic                 bit_valid;
  logic                 busy;
  logic                 done;
  logic [DATA_BITS-1:0] data_out;
  logic                 par_err;
`ifdef ERR_CNT_EN
  logic [CNT_W-1:0]     err_cnt;

  modport master (output start, bit_in, bit_valid,
                  input  busy, done, data_out, par_err, err_cnt);
  modport slave  (input  start, bit_in, bit_valid,
                  output busy, done, data_out, par_err, err_cnt);
`else
  modport master (output start, bit_in, bit_valid,
                  input  busy, done, data_out, par_err);
  modport slave  (input  start, bit_in, bit_valid,
                  output busy, done, data_out, par_err);
`endif
endinterface

// File: rtl/parity_accum.sv
// 1-bit registered XOR accumulator.
//   clk, rst_n : clock and synchronous active-low reset
//   clr        : synchronous clear (priority over en)
//   en, d      : when en=1, q <= q ^ d
//   q          : accumulated parity
module parity_accum (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!rst_n)   q <= 1'b0;
    else if (clr) q <= 1'b0;
    else if (en)  q <= q ^ d;
  end

endmodule

// File: rtl/serial_parity_checker.sv
// Serial frame receiver: DATA_BITS data bits (LSB first) followed by one
// even-parity bit. Presents the word and a pass/fail flag with a one-cycle
// done strobe.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : serial_parity_checker_if.slave (start/bit_in/bit_valid in;
//                busy/done/data_out/par_err[/err_cnt] out)
// Optional feature macro: ERR_CNT_EN (saturating failed-frame counter)
//
// state | meaning
// IDLE  | waiting for start, bit_valid ignored
// DATA  | shifting in data bits, accumulating parity
// PAR   | waiting for the parity bit
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_BITS = 8
`ifdef ERR_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_parity_checker_if.slave bus
);

  localparam int CW = $clog2(DATA_BITS + 1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shift_next;
  logic [DATA_BITS:0]   shift_cat;
  logic                 par_q;
  logic                 par_bad;
  logic                 frame_end;

  // New bit enters at the MSB; concatenation keeps this legal for DATA_BITS=1.
  always_comb begin
    shift_cat  = {bus.bit_in, shreg};
    shift_next = shift_cat[DATA_BITS:1];
  end

  assign par_bad   = par_q ^ bus.bit_in ^ (PAR_MODE == PAR_MODE_ODD);
  assign frame_end = (state == PAR) && bus.bit_valid && !bus.start;

  parity_accum u_par (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.start),
    .en    ((state == DATA) && bus.bit_valid && !bus.start),
    .d     (bus.bit_in),
    .q     (par_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      shreg        <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.data_out <= '0;
      bus.par_err  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (bus.start) begin
        // Start wins over bit_valid and aborts any frame in progress.
        state    <= DATA;
        cnt      <= '0;
        shreg    <= '0;
        bus.busy <= 1'b1;
      end else begin
        case (state)
          IDLE: bus.busy <= 1'b0;
          DATA: begin
            if (bus.bit_valid) begin
              shreg <= shift_next;
              cnt   <= cnt + CW'(1);
              if (cnt == CW'(DATA_BITS - 1)) state <= PAR;
            end
          end
          PAR: begin
            if (bus.bit_valid) begin
              bus.data_out <= shreg;
              bus.par_err  <= par_bad;
              bus.done     <= 1'b1;
              bus.busy     <= 1'b0;
              state        <= IDLE;
            end
          end
          default: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef ERR_CNT_EN
  // Updated on the same edge as par_err so the new count is visible with done.
  always_ff @(posedge clk) begin
    if (!rst_n)
      bus.err_cnt <= '0;
    else if (frame_end && par_bad && (bus.err_cnt != {CNT_W{1'b1}}))
      bus.err_cnt <= bus.err_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed self-checking bench for serial_parity_checker (DATA_BITS=8).
// With ERR_CNT_EN defined the checker is built with CNT_W=2 and the
// saturating error counter is exercised as well.
module tb_serial_parity_checker;

  localparam int DATA_BITS = 8;
`ifdef ERR_CNT_EN
  localparam int CNT_W = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef ERR_CNT_EN
  serial_parity_checker_if #(.DATA_BITS(DATA_BITS), .CNT_W(CNT_W)) bus ();
  serial_parity_checker #(.DATA_BITS(DATA_BITS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );
`else
  serial_parity_checker_if #(.DATA_BITS(DATA_BITS)) bus ();
  serial_parity_checker #(.DATA_BITS(DATA_BITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int lat;
  logic status_ok;
  int d0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit in the frame, optionally preceded by idle gap cycles; tracks
  // that busy stays high and done stays low before the parity bit.
  task automatic put_bit(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      bus.bit_valid = 1'b0;
      tick();
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) status_ok = 1'b0;
    end
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    tick();
  endtask

  // Full frame; returns with done expected high. lat = START cycle to DONE cycle.
  task automatic send_frame(input logic [7:0] word, input logic par, input bit gaps);
    int s;
    status_ok     = 1'b1;
    bus.start     = 1'b1;
    bus.bit_valid = 1'b0;
    s = cyc;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) begin
      put_bit(word[i], gaps ? (i % 3) + 1 : 0);
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) status_ok = 1'b0;
    end
    put_bit(par, gaps ? 2 : 0);
    bus.bit_valid = 1'b0;
    lat = cyc - s;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.bit_in = 1'b0;
    bus.bit_valid = 1'b0;

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_data", 32'(bus.data_out), 32'h0);
    check("rst_perr", 32'(bus.par_err), 32'd0);
`ifdef ERR_CNT_EN
    check("rst_ecnt", 32'(bus.err_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // 0xA5, good parity, continuous bits: DONE at START+10
    send_frame(8'hA5, 1'b0, 1'b0);
    check("a5_done", 32'(bus.done), 32'd1);
    check("a5_lat", 32'(lat), 32'd10);
    check("a5_data", 32'(bus.data_out), 32'hA5);
    check("a5_perr", 32'(bus.par_err), 32'd0);
    check("a5_busy_seq", 32'(status_ok), 32'd1);
`ifdef ERR_CNT_EN
    check("a5_ecnt", 32'(bus.err_cnt), 32'd0);
`endif
    tick();
    check("a5_done_1cyc", 32'(bus.done), 32'd0);
    check("a5_busy_after", 32'(bus.busy), 32'd0);

    // 0xA5, bad parity
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5b_perr", 32'(bus.par_err), 32'd1);
`ifdef ERR_CNT_EN
    check("a5b_ecnt", 32'(bus.err_cnt), 32'd1);
`endif

    // 0x01 parity 1, started in the DONE cycle of the previous frame
    d0 = done_cnt;
    send_frame(8'h01, 1'b1, 1'b0);
    check("x01_data", 32'(bus.data_out), 32'h01);
    check("x01_perr", 32'(bus.par_err), 32'd0);
    check("x01_lat", 32'(lat), 32'd10);
`ifdef ERR_CNT_EN
    check("x01_ecnt", 32'(bus.err_cnt), 32'd1);
`endif
    tick();
    check("b2b_dones", 32'(done_cnt - d0), 32'd2);

    // 0x3C with idle gaps between bits
    d0 = done_cnt;
    send_frame(8'h3C, 1'b0, 1'b1);
    check("gap_done", 32'(bus.done), 32'd1);
    check("gap_data", 32'(bus.data_out), 32'h3C);
    check("gap_perr", 32'(bus.par_err), 32'd0);
    check("gap_busy_seq", 32'(status_ok), 32'd1);
    tick();
    check("gap_dones", 32'(done_cnt - d0), 32'd1);

    // Abort after 4 bits, then full 0xFF
    d0 = done_cnt;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int i = 0; i < 4; i++) put_bit(1'b0, 0);
    bus.bit_valid = 1'b0;
    check("abort_keep_data", 32'(bus.data_out), 32'h3C);
    send_frame(8'hFF, 1'b0, 1'b0);
    check("ff_data", 32'(bus.data_out), 32'hFF);
    check("ff_perr", 32'(bus.par_err), 32'd0);
    check("ff_lat", 32'(lat), 32'd10);
    tick();
    check("abort_dones", 32'(done_cnt - d0), 32'd1);

    // Reset for one cycle mid-frame
    d0 = done_cnt;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int i = 0; i < 3; i++) put_bit(1'b1, 0);
    bus.bit_valid = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.bit_valid = 1'b0;
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_done", 32'(bus.done), 32'd0);
    check("mrst_data", 32'(bus.data_out), 32'h0);
    check("mrst_perr", 32'(bus.par_err), 32'd0);
`ifdef ERR_CNT_EN
    check("mrst_ecnt", 32'(bus.err_cnt), 32'd0);
`endif
    repeat (4) tick();
    check("mrst_nodone", 32'(done_cnt - d0), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0);
    check("x5a_data", 32'(bus.data_out), 32'h5A);
    check("x5a_perr", 32'(bus.par_err), 32'd0);
    tick();

    // START in IDLE with bit_valid=1: that bit is discarded
    bus.start = 1'b1; bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) put_bit(1'b0, 0);
    put_bit(1'b0, 0);
    bus.bit_valid = 1'b0;
    check("disc_done", 32'(bus.done), 32'd1);
    check("disc_data", 32'(bus.data_out), 32'h00);
    check("disc_perr", 32'(bus.par_err), 32'd0);
    tick();

`ifdef ERR_CNT_EN
    // Saturation with CNT_W=2: 1,2,3,3,3
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    send_frame(8'h01, 1'b0, 1'b0);
    check("sat1", 32'(bus.err_cnt), 32'd1);
    send_frame(8'h03, 1'b1, 1'b0);
    check("sat2", 32'(bus.err_cnt), 32'd2);
    send_frame(8'h80, 1'b0, 1'b0);
    check("sat3", 32'(bus.err_cnt), 32'd3);
    send_frame(8'h07, 1'b0, 1'b0);
    check("sat4", 32'(bus.err_cnt), 32'd3);
    send_frame(8'h00, 1'b1, 1'b0);
    check("sat5", 32'(bus.err_cnt), 32'd3);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_parity_checker.md
# serial_parity_checker

Serial frame receiver that consumes a bit stream one bit per valid cycle, accumulates an XOR parity over a fixed-length data word, checks it against a trailing parity bit, and presents the word with a pass/fail flag. It sits directly downstream of the XOR parity cell: the running parity is that cell's function applied sequentially, and this block adds the framing, counting and result handshake around it.

## Interface
- DATA_BITS, 8, data bits per frame (1..32)
- CNT_W, 8, width of error counter (present only with ERR_CNT_EN)

- CLK  input  1  sole clock, rising edge
- RST_N  input  1  synchronous, active-low reset
- START  input  1  frame start pulse; (re)starts a frame
- BIT_IN  input  1  serial data/parity bit
- BIT_VALID  input  1  BIT_IN is sampled this cycle
- BUSY  output  1  frame in progress (DATA or PAR state)
- DONE  output  1  one-cycle result strobe
- DATA_OUT  output  DATA_BITS  last received word, LSB first on wire
- PAR_ERR  output  1  last frame failed even-parity check
- ERR_CNT  output  CNT_W  saturating count of failed frames (ERR_CNT_EN only)

## Operation
- States: IDLE, DATA, PAR.
- IDLE: BIT_VALID ignored. START=1 -> DATA; bit counter, shift register, running parity cleared.
- DATA: on BIT_VALID=1, BIT_IN shifted in at MSB, word shifts right (first bit ends at DATA_OUT[0]); running parity ^= BIT_IN; counter++. When counter reaches DATA_BITS-1 with BIT_VALID=1 -> PAR. BIT_VALID=0 cycles: hold everything.
- PAR: on BIT_VALID=1, PAR_ERR_next = running parity ^ BIT_IN (even parity: total ones incl. parity bit must be even); DATA_OUT <= shift register; DONE pulsed next cycle; -> IDLE.
- START in DATA or PAR (any BIT_VALID): frame aborted, state -> DATA, counter/shift/parity cleared, no DONE, DATA_OUT/PAR_ERR unchanged. START wins over BIT_VALID in the same cycle.
- START in IDLE with BIT_VALID=1: bit discarded; first data bit is the next valid bit.
- Counter width: $clog2(DATA_BITS+1); never wraps within a frame.

## Timing
- Reset (RST_N=0 at a rising edge): state IDLE, BUSY=0, DONE=0, DATA_OUT=0, PAR_ERR=0, ERR_CNT=0. Reset mid-frame discards the frame, no DONE.
- BUSY: registered; high from cycle after START until cycle after parity bit sampled.
- DONE: high exactly one cycle, the cycle after the parity bit is sampled; DATA_OUT and PAR_ERR valid with DONE and held until next DONE.
- Minimum START-to-DONE latency: DATA_BITS+2 cycles (continuous BIT_VALID from cycle after START).
- Back-to-back: START may be asserted in the DONE cycle; DONE unaffected.

## Configuration
- ERR_CNT_EN defined: ERR_CNT port and CNT_W-bit register present; increments by 1 in the DONE cycle when PAR_ERR=1; saturates at all-ones; cleared only by reset.
- ERR_CNT_EN undefined: no ERR_CNT port, no counter logic; all other behaviour identical.

## Structure
- Shared package/header parity_pkg: state encodings (IDLE=2'd0, DATA=2'd1, PAR=2'd2), parity-mode constant (even).
- Sub-module parity_accum: 1-bit registered XOR accumulator with synchronous clear and enable; one instance holds the running parity.

## Test plan
- Reset then START, DATA_BITS=8, bits of 0xA5 LSB first, parity 0 -> DONE one cycle at START+10, DATA_OUT=0xA5, PAR_ERR=0, ERR_CNT=0.
- Same frame with parity bit 1 -> PAR_ERR=1, ERR_CNT=1; next frame 0x01 parity 1 -> PAR_ERR=0, DATA_OUT=0x01, ERR_CNT stays 1.
- Frame 0x3C with BIT_VALID=0 gaps of 1-3 cycles between bits -> DATA_OUT=0x3C, DONE only after parity bit, BUSY high throughout.
- START after 4 data bits, then full frame 0xFF parity 0 -> single DONE, DATA_OUT=0xFF, PAR_ERR=0; aborted frame produces no DONE.
- RST_N=0 for one cycle mid-frame -> all outputs zero next cycle, no DONE, following frame 0x5A parity 0 received correctly.
- ERR_CNT_EN, CNT_W=2, five bad-parity frames -> ERR_CNT sequence 1,2,3,3,3.
